// File: rtl/mem_initiator.sv
// rtl/mem_initiator.sv - single-outstanding command initiator for the single-port memory
// Optional MEM_INIT_RETRY_EN: re-issue a command after a memory error, up to MAX_RETRY times.
module mem_initiator #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int TIMEOUT   = 16,
  parameter int MAX_RETRY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic [1:0]        rsp_error_code,
  output logic              mem_write_enable,
  output logic              mem_read_enable,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic              mem_ready,
  input  logic              mem_busy,
  input  logic              mem_valid,
  input  logic              mem_error,
  input  logic [1:0]        mem_error_code
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int RW = $clog2(MAX_RETRY + 2);
`ifdef MEM_INIT_RETRY_EN
  localparam int RETRY_LIMIT = MAX_RETRY;
`else
  localparam int RETRY_LIMIT = 0;
`endif

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [1:0]        code_q, code_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      tmo_q   <= '0;
      retry_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      code_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      tmo_q   <= tmo_d;
      retry_q <= retry_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    wr_d             = wr_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    tmo_d            = tmo_q;
    retry_d          = retry_q;
    rdata_d          = rdata_q;
    err_d            = err_q;
    code_d           = code_q;
    mem_write_enable = 1'b0;
    mem_read_enable  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          wr_d    = cmd_write;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          retry_d = '0;
          rdata_d = '0;
          err_d   = 1'b0;
          code_d  = 2'b00;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_ready && !mem_busy) begin
          mem_write_enable = wr_q;
          mem_read_enable  = !wr_q;
          tmo_d            = '0;
          state_d          = WAIT;
        end
      end
      WAIT: begin
        // Error takes priority over a simultaneous valid pulse.
        if (mem_error) begin
          rdata_d = '0;
          err_d   = 1'b1;
          code_d  = mem_error_code;
          if (retry_q != RW'(RETRY_LIMIT)) begin
            retry_d = retry_q + 1'b1;
            state_d = ISSUE;
          end else begin
            state_d = RESP;
          end
        end else if (mem_valid) begin
          rdata_d = wr_q ? '0 : mem_read_data;
          err_d   = 1'b0;
          code_d  = 2'b00;
          state_d = RESP;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          code_d  = 2'b11;
          state_d = RESP;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Gated by reset so the handshake is closed while reset is held.
  assign cmd_ready      = (state_q == IDLE) && reset;
  assign rsp_valid      = (state_q == RESP);
  assign rsp_rdata      = rdata_q;
  assign rsp_error      = err_q;
  assign rsp_error_code = code_q;
  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;

endmodule

// File: tb/tb_mem_initiator.sv
// tb/tb_mem_initiator.sv - directed self-checking bench for mem_initiator
module tb_mem_initiator;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [7:0] cmd_addr, cmd_wdata;
  logic       rsp_valid, rsp_ready, rsp_error;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_error_code;
  logic       mem_write_enable, mem_read_enable;
  logic [7:0] mem_address, mem_write_data, mem_read_data;
  logic       mem_ready, mem_busy, mem_valid, mem_error;
  logic [1:0] mem_error_code;

  int n_checks = 0;
  int n_fail   = 0;
  int strobes  = 0;
  int base;
  logic [7:0] held;

  mem_initiator dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .rsp_error_code(rsp_error_code),
    .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .mem_ready(mem_ready), .mem_busy(mem_busy),
    .mem_valid(mem_valid), .mem_error(mem_error), .mem_error_code(mem_error_code)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_write_enable || mem_read_enable) strobes++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic wr, input logic [7:0] addr, input logic [7:0] data);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = data;
    tick();
    cmd_valid = 1'b0;
    cmd_addr  = 8'h00;
    cmd_wdata = 8'h00;
    #1;
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_eq("back_to_idle_ready", cmd_ready, 1);
    check_eq("back_to_idle_rsp", rsp_valid, 0);
  endtask

  initial begin
    reset = 1'b0;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
    rsp_ready = 0; mem_read_data = 0; mem_ready = 1; mem_busy = 0;
    mem_valid = 0; mem_error = 0; mem_error_code = 0;
    tick();
    tick();
    check_eq("rst_cmd_ready", cmd_ready, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_mem_addr", mem_address, 0);
    check_eq("rst_strobes", {mem_write_enable, mem_read_enable}, 0);
    reset = 1'b1;
    #1;
    check_eq("post_rst_ready", cmd_ready, 1);

    // completion pulse while idle is ignored
    mem_valid = 1'b1;
    tick();
    mem_valid = 1'b0;
    tick();
    check_eq("idle_pulse_ignored", rsp_valid, 0);

    // 1: write 0xAA @0x05, valid 2 cycles after strobe
    base = strobes;
    send_cmd(1'b1, 8'h05, 8'hAA);
    check_eq("t1_we", mem_write_enable, 1);
    check_eq("t1_re", mem_read_enable, 0);
    check_eq("t1_addr", mem_address, 8'h05);
    check_eq("t1_data", mem_write_data, 8'hAA);
    check_eq("t1_cmd_ready_busy", cmd_ready, 0);
    tick();
    check_eq("t1_we_one_cycle", mem_write_enable, 0);
    tick();
    tick();
    mem_valid = 1'b1;
    tick();
    mem_valid = 1'b0;
    check_eq("t1_rsp_valid", rsp_valid, 1);
    check_eq("t1_rsp_error", rsp_error, 0);
    check_eq("t1_rsp_rdata", rsp_rdata, 8'h00);
    check_eq("t1_strobe_count", strobes - base, 1);
    finish_rsp();
    check_eq("t1_addr_hold", mem_address, 8'h05);

    // 2: read @0x05 returns 0xAA immediately
    send_cmd(1'b0, 8'h05, 8'h00);
    check_eq("t2_re", mem_read_enable, 1);
    check_eq("t2_we", mem_write_enable, 0);
    tick();
    mem_valid = 1'b1;
    mem_read_data = 8'hAA;
    tick();
    mem_valid = 1'b0;
    mem_read_data = 8'h00;
    check_eq("t2_rsp_valid", rsp_valid, 1);
    check_eq("t2_rsp_rdata", rsp_rdata, 8'hAA);
    check_eq("t2_rsp_error", rsp_error, 0);
    finish_rsp();

    // 3: memory busy for 4 cycles after command
    base = strobes;
    mem_busy = 1'b1;
    send_cmd(1'b0, 8'h33, 8'h00);
    for (int i = 0; i < 4; i++) begin
      check_eq("t3_no_strobe_busy", {mem_write_enable, mem_read_enable}, 0);
      if (i < 3) tick();
    end
    tick();
    mem_busy = 1'b0;
    #1;
    check_eq("t3_strobe_on_drop", mem_read_enable, 1);
    check_eq("t3_addr", mem_address, 8'h33);
    tick();
    mem_valid = 1'b1;
    mem_read_data = 8'h3C;
    tick();
    mem_valid = 1'b0;
    check_eq("t3_rsp_rdata", rsp_rdata, 8'h3C);
    check_eq("t3_strobe_count", strobes - base, 1);
    finish_rsp();

    // 4: no completion -> timeout after 16 WAIT cycles
    send_cmd(1'b1, 8'h10, 8'h77);
    tick();
    for (int i = 0; i < 15; i++) tick();
    check_eq("t4_not_yet", rsp_valid, 0);
    tick();
    check_eq("t4_rsp_valid", rsp_valid, 1);
    check_eq("t4_rsp_error", rsp_error, 1);
    check_eq("t4_code", rsp_error_code, 2'b11);
    check_eq("t4_rdata", rsp_rdata, 8'h00);
    finish_rsp();

    // 5: error code 01 together with valid; error wins, single strobe
    base = strobes;
    send_cmd(1'b0, 8'h21, 8'h00);
    tick();
    mem_error = 1'b1;
    mem_error_code = 2'b01;
    mem_valid = 1'b1;
    mem_read_data = 8'h55;
    tick();
    mem_error = 1'b0;
    mem_valid = 1'b0;
    mem_error_code = 2'b00;
    check_eq("t5_rsp_valid", rsp_valid, 1);
    check_eq("t5_rsp_error", rsp_error, 1);
    check_eq("t5_code", rsp_error_code, 2'b01);
    check_eq("t5_rdata", rsp_rdata, 8'h00);
    check_eq("t5_strobe_count", strobes - base, 1);
    finish_rsp();

    // 6: response held 5 cycles, then reset during WAIT of next command
    send_cmd(1'b0, 8'h44, 8'h00);
    tick();
    mem_valid = 1'b1;
    mem_read_data = 8'h9E;
    tick();
    mem_valid = 1'b0;
    mem_read_data = 8'h00;
    held = rsp_rdata;
    check_eq("t6_rdata", held, 8'h9E);
    for (int i = 0; i < 5; i++) begin
      check_eq("t6_hold_valid", rsp_valid, 1);
      check_eq("t6_hold_rdata", rsp_rdata, 8'h9E);
      tick();
    end
    finish_rsp();
    send_cmd(1'b1, 8'h66, 8'h99);
    tick();
    reset = 1'b0;
    #1;
    check_eq("t6_rst_ready", cmd_ready, 0);
    check_eq("t6_rst_rsp", rsp_valid, 0);
    check_eq("t6_rst_err", rsp_error, 0);
    check_eq("t6_rst_addr", mem_address, 0);
    check_eq("t6_rst_wdata", mem_write_data, 0);
    check_eq("t6_rst_strobes", {mem_write_enable, mem_read_enable}, 0);
    tick();
    reset = 1'b1;
    #1;
    check_eq("t6_ready_after", cmd_ready, 1);
    for (int i = 0; i < 3; i++) tick();
    check_eq("t6_no_rsp", rsp_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
